// File: rtl/rand_burst_ctrl_pkg.sv
// Shared constants for the randomizer burst sequencer: FSM encoding, seed width,
// pad byte and the seed builder.
package rand_burst_ctrl_pkg;

    localparam int          RAND_SEED_W = 15;
    localparam logic [7:0]  PAD_BYTE    = 8'hFF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_PAD   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Seed layout, MSB first: bsid | 11 | diuc | 1 | frame_num
    function automatic logic [RAND_SEED_W-1:0] build_seed(input logic [3:0] bsid,
                                                          input logic [3:0] diuc,
                                                          input logic [3:0] frame_num);
        return {bsid, 2'b11, diuc, 1'b1, frame_num};
    endfunction

endpackage

// File: rtl/rand_burst_ctrl_if.sv
// Descriptor, byte-source and randomizer-side signals of the burst sequencer.
interface rand_burst_ctrl_if #(parameter int LEN_W = 11);
    import rand_burst_ctrl_pkg::*;

    logic                   burst_start;
    logic [LEN_W-1:0]       burst_len;
    logic [LEN_W-1:0]       payload_len;
    logic [3:0]             diuc;
    logic [3:0]             frame_num;
    logic [3:0]             bsid;
    logic [7:0]             src_data;
    logic                   src_valid;
    logic                   src_ready;
    logic                   rand_in_bits;
    logic                   rand_in_valid;
    logic [RAND_SEED_W-1:0] rand_iv;
    logic                   rand_reload;
    logic                   busy;
    logic                   burst_done;
    logic                   len_err;

    modport master (
        output burst_start, burst_len, payload_len, diuc, frame_num, bsid,
        output src_data, src_valid,
        input  src_ready, rand_in_bits, rand_in_valid, rand_iv, rand_reload,
        input  busy, burst_done, len_err
    );

    modport slave (
        input  burst_start, burst_len, payload_len, diuc, frame_num, bsid,
        input  src_data, src_valid,
        output src_ready, rand_in_bits, rand_in_valid, rand_iv, rand_reload,
        output busy, burst_done, len_err
    );

endinterface

// File: rtl/rand_burst_ctrl_ser.sv
// Byte hold register that shifts out MSB first, one bit per clock while full.
// Exposes next-cycle full/bit so the parent can register its serial outputs.
module rand_burst_ctrl_ser (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    output logic       full,
    output logic       last,
    output logic       full_nxt,
    output logic       bit_nxt
);

    logic [7:0] sreg, sreg_d;
    logic [2:0] bit_idx, idx_d;

    // A load may coincide with the last bit of the previous byte (back-to-back bytes).
    always_comb begin
        sreg_d   = sreg;
        idx_d    = bit_idx;
        full_nxt = full;
        if (load) begin
            sreg_d   = din;
            idx_d    = 3'd0;
            full_nxt = 1'b1;
        end else if (full) begin
            if (bit_idx == 3'd7) begin
                full_nxt = 1'b0;
            end else begin
                sreg_d = {sreg[6:0], 1'b0};
                idx_d  = bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg    <= '0;
            bit_idx <= '0;
            full    <= 1'b0;
        end else begin
            sreg    <= sreg_d;
            bit_idx <= idx_d;
            full    <= full_nxt;
        end
    end

    assign last    = full && (bit_idx == 3'd7);
    assign bit_nxt = sreg_d[7];

endmodule

// File: rtl/rand_burst_ctrl.sv
// Per-burst sequencer: latches a descriptor, strobes the randomizer seed, serializes
// payload bytes MSB first and pads the rest of the allocation with ones.
module rand_burst_ctrl
    import rand_burst_ctrl_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    rand_burst_ctrl_if.slave  bus
);

    logic [2:0]       state, state_d;
    logic [LEN_W-1:0] pay_len, pad_len, bytes_taken, bytes_pad, clamp_len;
    logic [2:0]       pad_bit, pad_bit_d;
    logic             start_ok, take, pay_drained, pad_last;
    logic             ser_full, ser_last, ser_full_nxt, ser_bit_nxt;

    assign start_ok    = (state == ST_IDLE) && bus.burst_start;
    assign clamp_len   = (bus.payload_len > bus.burst_len) ? bus.burst_len : bus.payload_len;
    assign pay_drained = (bytes_taken == pay_len) && (!ser_full || ser_last);
    assign pad_last    = (pad_bit == 3'd7) && (bytes_pad == pad_len - 1'b1);

    // Ready again on the cycle bit 7 goes out, so bytes stream without a bubble.
    assign bus.src_ready = ((state == ST_LOAD) || (state == ST_SHIFT)) &&
                           (bytes_taken < pay_len) && (!ser_full || ser_last);
    assign take = bus.src_valid && bus.src_ready;

    rand_burst_ctrl_ser u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (take),
        .din      (bus.src_data),
        .full     (ser_full),
        .last     (ser_last),
        .full_nxt (ser_full_nxt),
        .bit_nxt  (ser_bit_nxt)
    );

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (start_ok) state_d = (bus.burst_len == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (pay_drained) state_d = (pad_len == '0) ? ST_DONE : ST_PAD;
            ST_PAD:   if (pad_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign pad_bit_d = (state == ST_PAD) ? pad_bit + 3'd1 : pad_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pay_len     <= '0;
            pad_len     <= '0;
            bytes_taken <= '0;
            bytes_pad   <= '0;
            pad_bit     <= '0;
        end else begin
            state <= state_d;
            if (start_ok) begin
                pay_len     <= clamp_len;
                pad_len     <= bus.burst_len - clamp_len;
                bytes_taken <= '0;
                bytes_pad   <= '0;
                pad_bit     <= '0;
            end else begin
                if (take) bytes_taken <= bytes_taken + 1'b1;
                pad_bit <= pad_bit_d;
                if (state == ST_PAD && pad_bit == 3'd7) bytes_pad <= bytes_pad + 1'b1;
            end
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rand_iv       <= '0;
            bus.len_err       <= 1'b0;
            bus.rand_reload   <= 1'b0;
            bus.busy          <= 1'b0;
            bus.burst_done    <= 1'b0;
            bus.rand_in_valid <= 1'b0;
            bus.rand_in_bits  <= 1'b0;
        end else begin
            if (start_ok) begin
                bus.rand_iv <= build_seed(bus.bsid, bus.diuc, bus.frame_num);
                bus.len_err <= bus.payload_len > bus.burst_len;
            end
            bus.rand_reload   <= state_d == ST_LOAD;
            bus.busy          <= state_d != ST_IDLE;
            bus.burst_done    <= state_d == ST_DONE;
            bus.rand_in_valid <= ((state_d == ST_SHIFT) && ser_full_nxt) || (state_d == ST_PAD);
            if (state_d == ST_PAD)
                bus.rand_in_bits <= PAD_BYTE[~pad_bit_d];
            else
                bus.rand_in_bits <= (state_d == ST_SHIFT) && ser_full_nxt && ser_bit_nxt;
        end
    end

endmodule

// File: tb/tb_rand_burst_ctrl.sv
// Scoreboard bench for rand_burst_ctrl: stimulus pushes expected bits/burst records,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_rand_burst_ctrl;
    localparam int LEN_W = 11;

    typedef logic [7:0] byte_t;
    typedef struct {
        logic [14:0] iv;
        logic        err;
        int          nbits;
        int          reload_cyc;
        int          done_cyc;
    } burst_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rand_burst_ctrl_if #(.LEN_W(LEN_W)) bus ();
    rand_burst_ctrl #(.LEN_W(LEN_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     nbits_seen = 0;
    bit     mon_en = 1'b0;
    burst_t exp_q[$];
    bit     exp_bits[$];
    byte_t  src_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented bit, reload and done against the scoreboard.
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            nbits_seen = 0;
        end else begin
            if (bus.rand_reload) begin
                chk("valid_during_reload", bus.rand_in_valid, 1'b0);
                if (exp_q.size() == 0) chk("spurious_reload", bus.rand_reload, 1'b0);
                else begin
                    chk("rand_iv", bus.rand_iv, exp_q[0].iv);
                    chk("reload_cycle", cyc, exp_q[0].reload_cyc);
                end
            end
            if (bus.rand_in_valid) begin
                if (exp_bits.size() == 0) chk("extra_bit", bus.rand_in_valid, 1'b0);
                else begin
                    chk("serial_bit", bus.rand_in_bits, exp_bits.pop_front());
                    nbits_seen++;
                end
            end
            if (bus.burst_done) begin
                if (exp_q.size() == 0) chk("spurious_done", bus.burst_done, 1'b0);
                else begin
                    burst_t e;
                    e = exp_q.pop_front();
                    chk("bits_per_burst", nbits_seen, e.nbits);
                    chk("len_err", bus.len_err, e.err);
                    chk("iv_stable", bus.rand_iv, e.iv);
                    chk("busy_in_done", bus.busy, 1'b1);
                    if (e.done_cyc >= 0) chk("done_cycle", cyc, e.done_cyc);
                end
                nbits_seen = 0;
            end
        end
    end

    // Caller fills src_q with payload_len bytes and sets bsid/diuc/frame_num.
    task automatic run_burst(input int len, input bit full_rate, input int gap_at, input int inj_at);
        burst_t r;
        int pl, cl, k;
        bit acc, done, v;
        pl = src_q.size();
        cl = (pl > len) ? len : pl;
        for (int i = 0; i < cl; i++)
            for (int b = 7; b >= 0; b--) exp_bits.push_back(src_q[i][b]);
        for (int i = 0; i < 8 * (len - cl); i++) exp_bits.push_back(1'b1);
        @(negedge clk);
        bus.burst_len   = LEN_W'(len);
        bus.payload_len = LEN_W'(pl);
        bus.burst_start = 1'b1;
        k = cyc;
        r.iv         = {bus.bsid, 2'b11, bus.diuc, 1'b1, bus.frame_num};
        r.err        = pl > len;
        r.nbits      = 8 * len;
        r.reload_cyc = (len == 0) ? -1 : k + 1;
        if (len == 0)                r.done_cyc = k + 1;
        else if (full_rate && cl > 0) r.done_cyc = k + 2 + 8 * len + ((gap_at >= 0) ? 3 : 0);
        else                         r.done_cyc = -1;
        exp_q.push_back(r);
        acc  = 1'b0;
        done = 1'b0;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(negedge clk);
            bus.burst_start = (t == inj_at);
            if (t == inj_at) begin
                bus.burst_len   = LEN_W'(1);
                bus.payload_len = LEN_W'(7);
                bus.bsid        = ~bus.bsid;
                bus.diuc        = ~bus.diuc;
            end
            if (acc) void'(src_q.pop_front());
            if (t == 0) chk("busy_after_start", bus.busy, 1'b1);
            if (bus.burst_done) done = 1'b1;
            else begin
                v = (src_q.size() > 0) && (full_rate || $urandom_range(3) != 0) &&
                    !(gap_at >= 0 && t >= gap_at && t < gap_at + 3);
                bus.src_valid = v;
                bus.src_data  = v ? src_q[0] : 8'($urandom);
                acc = v && bus.src_ready;
            end
        end
        chk("burst_done_seen", done, 1'b1);
        chk("bytes_left", src_q.size(), pl - cl);
        bus.burst_start = 1'b0;
        bus.src_valid   = 1'b0;
        src_q.delete();
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_ready", bus.src_ready, 1'b0);
    endtask

    task automatic set_fields(input logic [3:0] b, input logic [3:0] d, input logic [3:0] f);
        bus.bsid = b; bus.diuc = d; bus.frame_num = f;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_iv"},     bus.rand_iv, '0);
        chk({tag, "_reload"}, bus.rand_reload, 1'b0);
        chk({tag, "_valid"},  bus.rand_in_valid, 1'b0);
        chk({tag, "_bits"},   bus.rand_in_bits, 1'b0);
        chk({tag, "_busy"},   bus.busy, 1'b0);
        chk({tag, "_done"},   bus.burst_done, 1'b0);
        chk({tag, "_lenerr"}, bus.len_err, 1'b0);
        chk({tag, "_ready"},  bus.src_ready, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.burst_start = 1'b0; bus.burst_len = '0; bus.payload_len = '0;
        bus.src_valid = 1'b0; bus.src_data = '0;
        set_fields(4'h0, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Reference burst: iv 0x56B3, reload cycle 1, 16 bits on cycles 2..17, done 18
        set_fields(4'hA, 4'h5, 4'h3);
        src_q = '{8'hA5, 8'h3C};
        run_burst(2, 1'b1, -1, -1);

        // One zero byte then two pad bytes
        set_fields(4'h1, 4'h2, 4'h4);
        src_q = '{8'h00};
        run_burst(3, 1'b1, -1, -1);

        // Source stalls three cycles at a byte boundary
        set_fields(4'h7, 4'h9, 4'hE);
        src_q = '{8'hC3, 8'h96, 8'h0F};
        run_burst(3, 1'b1, 8, -1);

        // Start pulse mid-SHIFT must be ignored
        set_fields(4'h3, 4'hC, 4'h8);
        src_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_burst(4, 1'b1, -1, 12);

        // Zero-length burst: done next cycle, no reload, no bits
        set_fields(4'h5, 4'h6, 4'h7);
        run_burst(0, 1'b1, -1, -1);

        // Payload longer than allocation: clamp, len_err, two bytes taken
        set_fields(4'h9, 4'h1, 4'h2);
        src_q = '{8'h81, 8'h7E, 8'h11, 8'h22, 8'h33};
        run_burst(2, 1'b1, -1, -1);
        chk("len_err_sticky", bus.len_err, 1'b1);

        // Next accepted start clears len_err; zero payload means all padding
        set_fields(4'h2, 4'hB, 4'h6);
        run_burst(1, 1'b1, -1, -1);

        // Reset mid-SHIFT abandons the burst
        mon_en = 1'b0;
        @(negedge clk);
        set_fields(4'hF, 4'hF, 4'hF);
        bus.burst_len = LEN_W'(4); bus.payload_len = LEN_W'(4);
        bus.burst_start = 1'b1; bus.src_valid = 1'b1; bus.src_data = 8'h5A;
        @(negedge clk);
        bus.burst_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_valid", bus.rand_in_valid, 1'b1);
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        bus.src_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_bits.delete();
        exp_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
        set_fields(4'hA, 4'h5, 4'h3);
        src_q = '{8'hA5, 8'h3C};
        run_burst(2, 1'b1, -1, -1);

        // Randomized bursts with a bursty source
        for (int n = 0; n < 25; n++) begin
            int len, pl;
            len = $urandom_range(6);
            pl  = $urandom_range(len + 2);
            set_fields(4'($urandom), 4'($urandom), 4'($urandom));
            for (int i = 0; i < pl; i++) src_q.push_back(8'($urandom));
            run_burst(len, $urandom_range(1), -1, -1);
        end

        repeat (3) @(negedge clk);
        chk("bits_drained", exp_bits.size(), 0);
        chk("bursts_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
